muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file.
- Consumes REG_DATA1/REG_DATA2 as operands a/b. Produces result plus destination address rd_out, which feed WR_DATA/ADR_WR_REG on the write-back path.
- Radix-2, one bit per cycle, start/busy/done handshake. Runs alongside the single-cycle ALU for funct7=0000001 instructions.

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency WIDTH+1 cycles start->done; div-by-zero/overflow finish in 1 cycle.
// No backpressure: start is taken only in IDLE, else dropped. Define MULDIV_EARLY_OUT_EN for multiply early-out.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(DEPTH)-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic [$clog2(DEPTH)-1:0] rd_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic [1:0]               state;
    logic [2:0]               op_q;
    logic                     neg_q;
    logic [$clog2(DEPTH)-1:0] rd_q;
    logic [CW-1:0]            cnt;
    logic [2*WIDTH-1:0]       acc;
    logic [2*WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]         mplier;
    logic [WIDTH-1:0]         dvsr;

    // Operand signedness: a is signed for MUL/MULH/MULHSU/DIV/REM, b for MUL/MULH/DIV/REM.
    logic             a_sgn, b_sgn, neg_start;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, mul_zero, fast;
    logic [WIDTH-1:0] fast_res;

    assign a_sgn     = a[WIDTH-1] & ~(op == 3'd3 || op == 3'd5 || op == 3'd7);
    assign b_sgn     = b[WIDTH-1] & (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd6);
    assign a_mag     = a_sgn ? -a : a;
    assign b_mag     = b_sgn ? -b : b;
    assign neg_start = (op[2] && op[1]) ? a_sgn : (a_sgn ^ b_sgn);

    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    assign mul_zero = EARLY_OUT && !op[2] && (b_mag == '0);
    assign fast     = div_zero || div_ovf || mul_zero;

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = op[1] ? a : '1;
        else if (div_ovf)
            fast_res = op[1] ? '0 : a;
    end

    logic [2*WIDTH-1:0] acc_mul, prod;
    logic [WIDTH:0]     trial;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_next, q_next, mul_res, div_res;
    logic               last;

    assign acc_mul = acc + (mplier[0] ? mcand : '0);
    assign prod    = neg_q ? -acc_mul : acc_mul;
    assign mul_res = (op_q == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

    // Restoring step: shift next dividend bit into the partial remainder, keep it if the subtract fits.
    assign trial     = {acc[WIDTH-1:0], mplier[WIDTH-1]} - {1'b0, dvsr};
    assign no_borrow = ~trial[WIDTH];
    assign rem_next  = no_borrow ? trial[WIDTH-1:0] : {acc[WIDTH-2:0], mplier[WIDTH-1]};
    assign q_next    = {mplier[WIDTH-2:0], no_borrow};
    assign div_res   = op_q[1] ? (neg_q ? -rem_next : rem_next) : (neg_q ? -q_next : q_next);

    assign last = (cnt == CW'(WIDTH-1)) || (EARLY_OUT && !op_q[2] && ((mplier >> 1) == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rd_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            dvsr   <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        neg_q <= neg_start;
                        rd_q  <= rd_in;
                        if (fast) begin
                            result <= fast_res;
                            rd_out <= rd_in;
                            state  <= S_DONE;
                        end else begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a_mag};
                            mplier <= op[2] ? a_mag : b_mag;
                            dvsr   <= b_mag;
                            cnt    <= '0;
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (op_q[2]) begin
                        acc    <= {{WIDTH{1'b0}}, rem_next};
                        mplier <= q_next;
                    end else begin
                        acc    <= acc_mul;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (last) begin
                        result <= op_q[2] ? div_res : mul_res;
                        rd_out <= rd_q;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, done-cycle and hold checks, reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.WIDTH(32), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          at;
    } exp_t;

    exp_t exq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Expected start->done latency in cycles
    function automatic int lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] bm;
        if (o[2]) begin
            if (y == 32'h0) return 1;
            if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_EARLY_OUT_EN
        bm = (o <= 3'd1 && y[31]) ? -y : y;
        if (bm == 32'h0) return 1;
        for (int i = 31; i >= 0; i--)
            if (bm[i]) return i + 2;
        return 1;
`else
        bm = y;
        return 33;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            exp_t e;
            if (exq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: result %h rd_out %0d with no pending request (cycle %0d)", result, rd_out, cyc);
            end else begin
                e = exq.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                chk("done_cycle", cyc, e.at);
                chk("busy_at_done", {31'b0, busy}, 32'h0);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input logic [31:0] want);
        int   n;
        int   l;
        exp_t e;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: unit still busy after %0d cycles", n);
        end
        op = o; a = x; b = y; rd_in = r; start = 1'b1;
        l = lat(o, x, y);
        e.res = want; e.rd = r; e.at = cyc + l;
        exq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom); rd_in = 5'($urandom);
        chk("busy_after_accept", {31'b0, busy}, {31'b0, (l > 1)});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exq.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_rd_out", {27'b0, rd_out}, 32'h0);
        rst = 1'b1;

        issue(3'd0, 32'd7,          32'd6,          5'd5,  32'd42);
        issue(3'd1, 32'hFFFF_FFFF,  32'h2,          5'd1,  32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFFF,  32'h2,          5'd2,  32'h0000_0001);
        issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFF);
        issue(3'd5, 32'd100,        32'd7,          5'd6,  32'd14);
        issue(3'd7, 32'd100,        32'd7,          5'd7,  32'd2);
        issue(3'd5, 32'd100,        32'd0,          5'd8,  32'hFFFF_FFFF);
        issue(3'd7, 32'd100,        32'd0,          5'd9,  32'd100);
        issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0);
        issue(3'd4, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'hFFFF_FFFD);
        issue(3'd6, 32'd7,          32'hFFFF_FFFE,  5'd13, 32'd1);
        issue(3'd0, 32'hFFFF_FFFD,  32'd5,          5'd14, 32'hFFFF_FFF1);
        issue(3'd1, 32'h8000_0000,  32'h8000_0000,  5'd15, 32'h4000_0000);
        issue(3'd0, 32'h0001_2345,  32'h0,          5'd16, 32'h0);
        drain();

        // A start pulse mid-operation must be dropped.
        issue(3'd0, 32'h0001_2345, 32'h7FFF_FFFF, 5'd17, 32'h7FFE_DCBB);
        repeat (9) @(negedge clk);
        op = 3'd4; a = 32'd55; b = 32'd5; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        chk("result_hold", result, 32'h7FFE_DCBB);
        chk("rd_out_hold", {27'b0, rd_out}, 32'd17);

        // Reset mid-divide aborts without a done pulse.
        issue(3'd4, 32'd1000, 32'd7, 5'd18, 32'd142);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        exq.delete();
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_rd_out", {27'b0, rd_out}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        issue(3'd5, 32'd9, 32'd3, 5'd19, 32'd3);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
